// File: rtl/weight_server.sv
// weight_server: flattened weight RAM serving one weight per read handshake (num*N*N + N*right + left).
// Optional WEIGHT_RANGE_CHECK_EN: reads >= DEPTH return 0 with rd_err, writes >= DEPTH are ignored.
module weight_server #(
   parameter int N        = 100,
   parameter int LAYERS   = 4,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [31:0]       rd_addr,
   output logic              rd_resp,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err,
   input  logic              wr_en,
   input  logic [31:0]       wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy
);
   localparam int DEPTH  = LAYERS * N * N;
   localparam int ADDR_W = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              oor_q, oor_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_err_q, rd_err_d;
   logic              rd_oor, wr_ok;
   logic [DATA_W-1:0] mem [DEPTH];
`ifdef WEIGHT_RANGE_CHECK_EN
   assign rd_oor = rd_addr >= 32'(DEPTH);
   assign wr_ok  = wr_addr < 32'(DEPTH);
`else
   logic unused_hi;
   assign unused_hi = ^{rd_addr[31:ADDR_W], wr_addr[31:ADDR_W]};
   assign rd_oor    = 1'b0;
   assign wr_ok     = 1'b1;
`endif
   assign rd_resp = state_q == RESP;
   assign busy    = state_q != IDLE;
   assign rd_data = rd_data_q;
   assign rd_err  = rd_err_q;
   // Host writes land only while idle; a write alongside a request wins and the read is taken next cycle.
   always_ff @(posedge clk)
      if (!reset && wr_en && wr_ok && state_q == IDLE) mem[wr_addr[ADDR_W-1:0]] <= wr_data;
   // State and read-path registers; RAM contents survive reset.
   always_ff @(posedge clk)
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         oor_q     <= 1'b0;
         rd_data_q <= '0;
         rd_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         oor_q     <= oor_d;
         rd_data_q <= rd_data_d;
         rd_err_q  <= rd_err_d;
      end
   // Accept in IDLE, count out the RAM latency in WAIT (abort if the request drops), pulse once in RESP.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      oor_d     = oor_q;
      rd_data_d = rd_data_q;
      rd_err_d  = rd_err_q;
      case (state_q)
         IDLE: if (!wr_en && rd_req) begin
            state_d = WAIT;
            cnt_d   = '0;
            addr_d  = rd_addr[ADDR_W-1:0];
            oor_d   = rd_oor;
         end
         WAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (!rd_req) state_d = IDLE;
            else if (cnt_q == 4'(READ_LAT - 1)) begin
               state_d   = RESP;
               rd_data_d = oor_q ? '0 : mem[addr_q];
               rd_err_d  = oor_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
